// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared encodings and helpers for the load/store/writeback stage
//
// Purpose: op and funct3 encodings, the stage FSM state type and the
// access-size helpers used by lsu_wb_stage.
package rv_core_pkg;

  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_JAL   = 2'd3;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } lsu_state_e;

  // size is funct3[1:0]: 00 byte, 01 half, 1x word.
  // Forces the low address bits to the natural alignment of the access.
  function automatic logic [1:0] natural_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return lo;
      2'b01:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_wb_stage_load_align.sv
// rtl/lsu_wb_stage_load_align.sv - load lane select and sign/zero extension
//
// Purpose: picks the addressed byte/half/word out of a memory word and
// extends it to 32 bits.
// Ports:
//   rdata   in  32  memory read word
//   addr_lo in  2   byte offset within the word (already naturally aligned)
//   funct3  in  3   bit 2 selects zero-extension, bits 1:0 the size
//   data    out 32  extended load value
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext   = ~funct3[2];
    case (funct3[1:0])
      2'b00:   data = {{24{sext & lane_b[7]}}, lane_b};
      2'b01:   data = {{16{sext & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb_stage.sv
// rtl/lsu_wb_stage.sv - RV32 load/store and register-file writeback stage
//
// Purpose: accepts one execute-stage instruction at a time, runs loads and
// stores over a req/gnt/rvalid memory handshake and drives the register
// file write port.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ex_valid/ex_ready              execute handshake
//   ex_op, ex_funct3, ex_rd        instruction class, size/sign, destination
//   ex_result, ex_store_data,
//   ex_pc_plus4                    ALU result/address, store data, link value
//   mem_req/we/addr/be/wdata       memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata memory grant and load response
//   rf_we, rf_waddr, rf_wdata      register file write port
//   misalign_err                   one-cycle misaligned-access pulse
// Build option: LSU_MISALIGN_TRAP_EN adds misalign_err and drops misaligned
// accesses; without it the low address bits are forced to natural alignment.
module lsu_wb_stage
  import rv_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_op,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_pc_plus4,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  op_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] load_val;
  logic [1:0]  lo;
  logic        accept;
  logic        is_mem_in;
  logic        acc_misalign;
  logic        in_req;

  assign in_req    = (state_q == S_REQ);
  assign accept    = ex_valid && ((state_q == S_IDLE) || (state_q == S_WB));
  assign is_mem_in = (ex_op == OP_LOAD) || (ex_op == OP_STORE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign acc_misalign = is_mem_in && is_misaligned(ex_funct3[1:0], ex_result[1:0]);
  // Misaligned accesses never reach REQ, so the raw offset is already aligned.
  assign lo           = addr_q[1:0];
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= accept && acc_misalign;
  end
`else
  assign acc_misalign = 1'b0;
  assign lo           = natural_lo(f3_q[1:0], addr_q[1:0]);
`endif

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (lo),
    .funct3  (f3_q),
    .data    (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_WB: begin
        if (!accept)           state_d = S_IDLE;
        else if (acc_misalign) state_d = S_IDLE;
        else if (is_mem_in)    state_d = S_REQ;
        else                   state_d = S_WB;
      end
      S_REQ:   if (mem_gnt) state_d = (op_q == OP_STORE) ? S_IDLE : S_RESP;
      S_RESP:  if (mem_rvalid) state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU/JAL results go straight into the writeback registers on accept; a
  // load overwrites them only when its data arrives, so the port holds the
  // previous write while the load is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_ALU;
      f3_q       <= 3'd0;
      rd_q       <= 5'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      if (accept) begin
        op_q    <= ex_op;
        f3_q    <= ex_funct3;
        rd_q    <= ex_rd;
        addr_q  <= ex_result;
        sdata_q <= ex_store_data;
        if (!is_mem_in) begin
          rf_waddr_q <= ex_rd;
          rf_wdata_q <= (ex_op == OP_JAL) ? ex_pc_plus4 : ex_result;
        end
      end
      if ((state_q == S_RESP) && mem_rvalid) begin
        rf_waddr_q <= rd_q;
        rf_wdata_q <= load_val;
      end
    end
  end

  always_comb begin
    ex_ready  = (state_q == S_IDLE) || (state_q == S_WB);
    mem_req   = in_req;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    rf_we     = (state_q == S_WB) && (rf_waddr_q != 5'd0);
    rf_waddr  = rf_waddr_q;
    rf_wdata  = rf_wdata_q;
    if (in_req) begin
      mem_we   = (op_q == OP_STORE);
      mem_addr = {addr_q[31:2], 2'b00};
      case (f3_q[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << lo;
          mem_wdata = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << lo;
          mem_wdata = {2{sdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = sdata_q;
        end
      endcase
    end
  end

endmodule
